// File: rtl/ot_receiver_if.sv
// Receive-side bus bundle: serial line, tick, consumer handshake and status.
// master = receiver (ot_receiver), slave = line driver / consumer.
interface ot_receiver_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 Rx;
  logic                 clken;
  logic                 ready_clr;
  logic [DATA_BITS-1:0] data_out;
  logic                 ready;
  logic                 Rx_busy;
  logic                 frame_err;

  modport master (
    input  Rx, clken, ready_clr,
    output data_out, ready, Rx_busy, frame_err
  );

  modport slave (
    output Rx, clken, ready_clr,
    input  data_out, ready, Rx_busy, frame_err
  );
endinterface

// File: rtl/ot_receiver.sv
// UART receiver: 16x oversampled start + DATA_BITS (LSB first) + stop frame.
// Optional stop-bit checking and sticky frame_err via `OT_RX_FRAME_CHECK_EN.
module ot_receiver #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic             clk_50m,
  input  logic             rstn,
  ot_receiver_if.master    bus
);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 rx_meta, rx_s;
  state_t               state, state_nx;
  logic [3:0]           sample, sample_nx;
  logic [BW-1:0]        bit_pos, bit_pos_nx;
  logic [DATA_BITS-1:0] scratch, scratch_nx;
  logic [DATA_BITS-1:0] data_q, data_nx;
  logic                 ready_q, ready_nx;
  logic                 busy_q;
`ifdef OT_RX_FRAME_CHECK_EN
  logic                 ferr_q, ferr_nx;
`endif

  // Two-stage synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk_50m) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.Rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, counters, shift register and output updates
  always_comb begin
    state_nx   = state;
    sample_nx  = sample;
    bit_pos_nx = bit_pos;
    scratch_nx = scratch;
    data_nx    = data_q;
    ready_nx   = ready_q;
`ifdef OT_RX_FRAME_CHECK_EN
    ferr_nx    = ferr_q;
`endif

    if (bus.ready_clr) begin
      ready_nx = 1'b0;
`ifdef OT_RX_FRAME_CHECK_EN
      ferr_nx  = 1'b0;
`endif
    end

    case (state)
      IDLE: begin
        if (bus.clken && !rx_s) begin
          sample_nx = 4'd0;
          state_nx  = START;
        end
      end
      START: begin
        if (bus.clken) begin
          sample_nx = sample + 4'd1;
          if (sample == 4'd7) begin
            if (!rx_s) begin
              sample_nx  = 4'd0;
              bit_pos_nx = '0;
              state_nx   = DATA;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (bus.clken) begin
          sample_nx = sample + 4'd1;
          if (sample == 4'd15) begin
            scratch_nx[bit_pos] = rx_s;
            sample_nx = 4'd0;
            if (bit_pos == BW'(DATA_BITS - 1)) state_nx = STOP;
            else bit_pos_nx = bit_pos + BW'(1);
          end
        end
      end
      STOP: begin
        if (bus.clken) begin
          sample_nx = sample + 4'd1;
          if (sample == 4'd15) begin
            sample_nx = 4'd0;
            state_nx  = IDLE;
`ifdef OT_RX_FRAME_CHECK_EN
            if (rx_s) begin
              data_nx  = scratch;
              ready_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
`else
            data_nx  = scratch;
            ready_nx = 1'b1;
`endif
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; busy is registered from the next state
  always_ff @(posedge clk_50m) begin
    if (!rstn) begin
      state   <= IDLE;
      sample  <= 4'd0;
      bit_pos <= '0;
      scratch <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef OT_RX_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      sample  <= sample_nx;
      bit_pos <= bit_pos_nx;
      scratch <= scratch_nx;
      data_q  <= data_nx;
      ready_q <= ready_nx;
      busy_q  <= (state_nx != IDLE);
`ifdef OT_RX_FRAME_CHECK_EN
      ferr_q  <= ferr_nx;
`endif
    end
  end

  assign bus.data_out = data_q;
  assign bus.ready    = ready_q;
  assign bus.Rx_busy  = busy_q;
`ifdef OT_RX_FRAME_CHECK_EN
  assign bus.frame_err = ferr_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ot_receiver.sv
// Self-checking bench for ot_receiver: directed frames plus random bytes,
// compared against a frame-level model of what the consumer should see.
module tb_ot_receiver;
  localparam int unsigned DW          = 8;
  localparam int          BIT_CYC     = 64;               // 16 ticks x 4 clocks
  localparam int          FRAME_TICKS = 8 + 16 * DW + 16; // ticks with busy high

  logic clk_50m = 1'b0;
  logic rstn    = 1'b0;
  logic [1:0] div = 2'd0;

  ot_receiver_if #(.DATA_BITS(DW)) bus ();

  ot_receiver #(.DATA_BITS(DW)) dut (
    .clk_50m (clk_50m),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 clk_50m = ~clk_50m;

  // One-cycle sample tick every fourth clock
  always @(posedge clk_50m) begin
    div       <= div + 2'd1;
    bus.clken <= (div == 2'd3);
  end

  // Count ticks spent busy per frame; latch the total when busy drops
  int tick_cnt = 0;
  int last_len = 0;
  always @(posedge clk_50m) begin
    if (bus.Rx_busy) begin
      if (bus.clken) tick_cnt <= tick_cnt + 1;
    end else if (tick_cnt != 0) begin
      last_len <= tick_cnt;
      tick_cnt <= 0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level expectation of the consumer-visible outputs
  logic [DW-1:0] m_data  = '0;
  logic          m_ready = 1'b0;
  logic          m_ferr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic v, input int cyc);
    bus.Rx = v;
    repeat (cyc) @(negedge clk_50m);
  endtask

  // Full frame; a bad stop bit is driven low only long enough to be sampled
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_v, input int gap_bits);
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i], BIT_CYC);
    if (!stop_v) send_bit(1'b0, 40);
    send_bit(1'b1, BIT_CYC * gap_bits);
  endtask

  task automatic model_frame(input logic [DW-1:0] d, input logic stop_v);
`ifdef OT_RX_FRAME_CHECK_EN
    if (stop_v) begin
      m_data  = d;
      m_ready = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
`else
    if (stop_v || !stop_v) begin
      m_data  = d;
      m_ready = 1'b1;
    end
`endif
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_data"},  32'(bus.data_out),  32'(m_data));
    check({tag, "_ready"}, 32'(bus.ready),     32'(m_ready));
    check({tag, "_busy"},  32'(bus.Rx_busy),   32'd0);
    check({tag, "_ferr"},  32'(bus.frame_err), 32'(m_ferr));
  endtask

  task automatic do_clr(input string tag);
    bus.ready_clr = 1'b1;
    @(negedge clk_50m);
    bus.ready_clr = 1'b0;
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    check({tag, "_clr_ready"}, 32'(bus.ready),     32'd0);
    check({tag, "_clr_ferr"},  32'(bus.frame_err), 32'd0);
  endtask

  // Find the clock cycle holding the stop-sample tick (last busy tick)
  task automatic wait_stop_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_50m);
      if (bus.clken && bus.Rx_busy && tick_cnt == FRAME_TICKS - 1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    logic [DW-1:0] d;
    int gap;

    bus.Rx        = 1'b1;
    bus.ready_clr = 1'b0;
    repeat (4) @(negedge clk_50m);
    check_outs("reset");
    rstn = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk_50m);

    // 0xA5: outputs change the cycle after the stop-sample tick
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        wait_stop_tick(ok);
        check("a5_stop_tick_seen", 32'(ok), 32'd1);
        check("a5_ready_before", 32'(bus.ready), 32'd0);
        @(negedge clk_50m);
        check("a5_ready_after", 32'(bus.ready), 32'd1);
        check("a5_data_after", 32'(bus.data_out), 32'hA5);
        check("a5_busy_after", 32'(bus.Rx_busy), 32'd0);
      end
    join
    model_frame(8'hA5, 1'b1);
    check_outs("a5");
    check("a5_len", 32'(last_len), 32'(FRAME_TICKS));

    // Short low glitch: rejected at the mid-start check
    do_clr("pre_glitch");
    send_bit(1'b0, 16);
    send_bit(1'b1, 2 * BIT_CYC);
    check_outs("glitch");
    check("glitch_len", 32'(last_len), 32'd8);

    // 0x3C then clear, then clear coinciding with the 0x55 commit
    send_frame(8'h3C, 1'b1, 1);
    model_frame(8'h3C, 1'b1);
    check_outs("f3c");
    do_clr("f3c");
    fork
      send_frame(8'h55, 1'b1, 1);
      begin
        wait_stop_tick(ok);
        check("f55_stop_tick_seen", 32'(ok), 32'd1);
        bus.ready_clr = 1'b1;
        @(negedge clk_50m);
        bus.ready_clr = 1'b0;
        check("f55_commit_wins", 32'(bus.ready), 32'd1);
        check("f55_data", 32'(bus.data_out), 32'h55);
      end
    join
    model_frame(8'h55, 1'b1);
    check_outs("f55");

    // Back-to-back with a single stop bit, no clear in between
    send_frame(8'h00, 1'b1, 1);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, 1);
    model_frame(8'hFF, 1'b1);
    check_outs("b2b");
    check("b2b_len", 32'(last_len), 32'(FRAME_TICKS));

    // Bad stop bit after a good frame
    do_clr("pre_ferr");
    send_frame(8'h12, 1'b1, 1);
    model_frame(8'h12, 1'b1);
    check_outs("f12");
    send_frame(8'h34, 1'b0, 2);
    model_frame(8'h34, 1'b0);
    check_outs("bad_stop");
    do_clr("post_ferr");
    check_outs("post_ferr");

    // Reset in the middle of data bit 3, then a clean 0x81
    d = 8'h96;
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 3; i++) send_bit(d[i], BIT_CYC);
    send_bit(d[3], BIT_CYC / 2);
    rstn = 1'b0;
    @(negedge clk_50m);
    m_data = '0; m_ready = 1'b0; m_ferr = 1'b0;
    check_outs("mid_reset");
    rstn   = 1'b1;
    bus.Rx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk_50m);
    check_outs("post_reset_idle");
    send_frame(8'h81, 1'b1, 1);
    model_frame(8'h81, 1'b1);
    check_outs("f81");
    check("f81_len", 32'(last_len), 32'(FRAME_TICKS));

    // Random bytes, gaps and clears
    for (int n = 0; n < 20; n++) begin
      d   = DW'($urandom_range(0, (1 << DW) - 1));
      gap = int'($urandom_range(1, 3));
      send_frame(d, 1'b1, gap);
      model_frame(d, 1'b1);
      check_outs("rand");
      if ($urandom_range(0, 9) < 3) do_clr("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop if the run overstays its cycle budget
  initial begin
    repeat (90000) @(posedge clk_50m);
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
